// File: rtl/arb_pkg.sv
// Shared types and default sizes for the two-source round-robin arbiter.
//   grant_e   : grant / last-granted encoding (1 = source A, 0 = source B)
//   ARB_WIDTH : default data word width
//   ARB_CNT_W : default transfer counter width
package arb_pkg;

    typedef enum logic {
        GRANT_B = 1'b0,
        GRANT_A = 1'b1
    } grant_e;

    localparam int unsigned ARB_WIDTH = 8;
    localparam int unsigned ARB_CNT_W = 16;

endpackage

// File: rtl/mux_m.sv
// 2:1 word multiplexer.
//   data_a : word selected when sel_a = 1
//   data_b : word selected when sel_a = 0
//   sel_a  : select
//   data_o : selected word (combinational)
module mux_m #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sel_a,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = sel_a ? data_a : data_b;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter with one holding register per source and a
// registered valid/ready output stage feeding the downstream mux select.
//   clk, rst            : clock, synchronous active-high reset
//   a_data/a_valid/a_ready : source A stream (ready = A holding reg empty)
//   b_data/b_valid/b_ready : source B stream (ready = B holding reg empty)
//   out_data/out_valid/out_ready : registered output stream
//   sel_a               : origin of out_data (1 = A, 0 = B)
//   xfer_cnt            : completed output handshakes, wraps
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = ARB_WIDTH,
    parameter int unsigned CNT_W = ARB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_a,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [WIDTH-1:0] r_hold_a;
    logic [WIDTH-1:0] r_hold_b;
    logic             r_full_a;
    logic             r_full_b;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_sel_a;
    grant_e           r_last_a;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic             w_slot_free;
    logic             w_grant_vld;
    grant_e           w_grant;
    logic [WIDTH-1:0] w_mux_data;

    // Readiness comes straight from the full flags: no path from out_ready.
    assign a_ready   = ~r_full_a;
    assign b_ready   = ~r_full_b;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_a     = r_sel_a;
    assign xfer_cnt  = r_xfer_cnt;

    assign w_slot_free = ~r_out_valid | out_ready;

    // Next-grant selection; on a tie the source not granted last wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = GRANT_B;
        if (w_slot_free) begin
            if (r_full_a && r_full_b) begin
                w_grant_vld = 1'b1;
                w_grant     = (r_last_a == GRANT_A) ? GRANT_B : GRANT_A;
            end else if (r_full_a) begin
                w_grant_vld = 1'b1;
                w_grant     = GRANT_A;
            end else if (r_full_b) begin
                w_grant_vld = 1'b1;
                w_grant     = GRANT_B;
            end
        end
    end

    // Hold-to-output selection driven by the current grant.
    mux_m #(.WIDTH(WIDTH)) u_mux (
        .data_a (r_hold_a),
        .data_b (r_hold_b),
        .sel_a  (w_grant == GRANT_A),
        .data_o (w_mux_data)
    );

    // Holding registers, arbitration pointer, output stage and counter.
    // Capture needs an empty register and a grant needs a full one, so a
    // register is never filled and drained in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_a    <= '0;
            r_hold_b    <= '0;
            r_full_a    <= 1'b0;
            r_full_b    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_a     <= 1'b0;
            r_last_a    <= GRANT_B;
            r_xfer_cnt  <= '0;
        end else begin
            if (a_valid && !r_full_a) begin
                r_hold_a <= a_data;
                r_full_a <= 1'b1;
            end
            if (b_valid && !r_full_b) begin
                r_hold_b <= b_data;
                r_full_b <= 1'b1;
            end

            if (w_grant_vld) begin
                r_out_data  <= w_mux_data;
                r_out_valid <= 1'b1;
                r_sel_a     <= (w_grant == GRANT_A);
                r_last_a    <= w_grant;
                if (w_grant == GRANT_A) begin
                    r_full_a <= 1'b0;
                end else begin
                    r_full_b <= 1'b0;
                end
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end

            if (r_out_valid && out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: a directed vector table plus hand-written
// saturation, counter-wrap and mid-operation reset sequences.
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_ready;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_a;
    logic [15:0] xfer_cnt;

    // Narrow-counter instance sharing the same stimulus.
    logic        a_ready4;
    logic        b_ready4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        sel_a4;
    logic [3:0]  xfer_cnt4;

    int total = 0;
    int bad   = 0;

    mux_rr_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_a     (sel_a),
        .xfer_cnt  (xfer_cnt)
    );

    mux_rr_arbiter #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready4),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .sel_a     (sel_a4),
        .xfer_cnt  (xfer_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [7:0]  ad;
        logic        bv;
        logic [7:0]  bd;
        logic        ordy;
        logic        eov;
        logic [7:0]  eod;
        logic        esa;
        logic        ear;
        logic        ebr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy,
                       input logic eov, input logic [7:0] eod, input logic esa,
                       input logic ear, input logic ebr, input logic [15:0] ecnt);
        vec_t v;
        v.rst = r;   v.av = av;   v.ad = ad;   v.bv = bv;   v.bd = bd;
        v.ordy = ordy; v.eov = eov; v.eod = eod; v.esa = esa;
        v.ear = ear; v.ebr = ebr; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    initial begin
        int na;
        int nb;
        logic take_a;
        logic take_b;
        logic       exp_sel;
        logic [7:0] exp_d;
        int         ecnt;

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;

        //   rst av ad     bv bd     ordy | ov od     sa ar br cnt
        // reset with both sources offering; nothing may be captured
        add(1, 1, 8'h01, 1, 8'h02, 1,   0, 8'h00, 0, 1, 1, 0);
        add(1, 1, 8'h01, 1, 8'h02, 1,   0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 1, 1, 0);
        // first tie: A wins
        add(0, 1, 8'hAA, 1, 8'hBB, 1,   0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hAA, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hBB, 0, 1, 1, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'hBB, 0, 1, 1, 2);
        // second tie: A first again
        add(0, 1, 8'hA1, 1, 8'hB1, 1,   0, 8'hBB, 0, 0, 0, 2);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hA1, 1, 1, 0, 2);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hB1, 0, 1, 1, 3);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'hB1, 0, 1, 1, 4);
        // single source A: 0x11 then 0x22, two cycles apart
        add(0, 1, 8'h11, 0, 8'h00, 1,   0, 8'hB1, 0, 0, 1, 4);
        add(0, 1, 8'h22, 0, 8'h00, 1,   1, 8'h11, 1, 1, 1, 4);
        add(0, 1, 8'h22, 0, 8'h00, 1,   0, 8'h11, 1, 0, 1, 5);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h22, 1, 1, 1, 5);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h22, 1, 1, 1, 6);
        // backpressure: 0x5C stalls, both holding registers fill
        add(0, 1, 8'h5C, 0, 8'h00, 0,   0, 8'h22, 1, 0, 1, 6);
        add(0, 1, 8'h66, 1, 8'h77, 0,   1, 8'h5C, 1, 1, 0, 6);
        add(0, 1, 8'h66, 0, 8'h00, 0,   1, 8'h5C, 1, 0, 0, 6);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h5C, 1, 0, 0, 6);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h5C, 1, 0, 0, 6);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h5C, 1, 0, 0, 6);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h5C, 1, 0, 0, 6);
        // release: three words drain back to back, B wins the tie
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h77, 0, 0, 1, 7);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h66, 1, 1, 1, 8);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h66, 1, 1, 1, 9);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;   a_valid = vecs[i].av; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_data = vecs[i].bd; out_ready = vecs[i].ordy;
            tick();
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].eod));
            check($sformatf("v%0d sel_a", i),     32'(sel_a),     32'(vecs[i].esa));
            check($sformatf("v%0d a_ready", i),   32'(a_ready),   32'(vecs[i].ear));
            check($sformatf("v%0d b_ready", i),   32'(b_ready),   32'(vecs[i].ebr));
            check($sformatf("v%0d xfer_cnt", i),  32'(xfer_cnt),  32'(vecs[i].ecnt));
        end

        // Saturation: both sources always valid, strict A/B alternation.
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        na = 0;
        nb = 0;
        for (int e = 1; e <= 20; e++) begin
            a_data  = 8'h10 + 8'(na);
            b_data  = 8'h80 + 8'(nb);
            a_valid = 1'b1;
            b_valid = 1'b1;
            take_a  = a_ready;
            take_b  = b_ready;
            tick();
            if (take_a) na++;
            if (take_b) nb++;
            if (e >= 2) begin
                exp_sel = ((e % 2) == 0);
                exp_d   = exp_sel ? 8'h10 + 8'((e - 2) / 2) : 8'h80 + 8'((e - 3) / 2);
                check($sformatf("sat%0d out_valid", e), 32'(out_valid), 32'd1);
                check($sformatf("sat%0d sel_a", e),     32'(sel_a),     32'(exp_sel));
                check($sformatf("sat%0d out_data", e),  32'(out_data),  32'(exp_d));
            end
            ecnt = (e > 2) ? e - 2 : 0;
            check($sformatf("sat%0d xfer_cnt", e),   32'(xfer_cnt),  32'(ecnt));
            check($sformatf("sat%0d xfer_cnt4", e),  32'(xfer_cnt4), 32'(ecnt % 16));
        end

        // Stall so both holding registers are full, then reset mid-operation.
        out_ready = 1'b0;
        a_data = 8'hE1; b_data = 8'hE2;
        tick();
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall a_ready",   32'(a_ready),   32'd0);
        check("stall b_ready",   32'(b_ready),   32'd0);
        check("stall xfer_cnt",  32'(xfer_cnt),  32'd18);

        rst = 1'b1;
        tick();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        check("mrst out_valid", 32'(out_valid), 32'd0);
        check("mrst xfer_cnt",  32'(xfer_cnt),  32'd0);
        check("mrst xfer_cnt4", 32'(xfer_cnt4), 32'd0);
        check("mrst a_ready",   32'(a_ready),   32'd1);
        check("mrst b_ready",   32'(b_ready),   32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post%0d out_valid", k), 32'(out_valid), 32'd0);
            check($sformatf("post%0d xfer_cnt", k),  32'(xfer_cnt),  32'd0);
            check($sformatf("post%0d a_ready", k),   32'(a_ready),   32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-source round-robin arbiter that buffers one word per source and drives a registered output stage. It sits directly upstream of the team's 2:1 word multiplexer (`mux_m`): it generates that mux's select from arbitration state and delivers a single valid/ready stream to the next stage. It also exports the grant and a completed-transfer count for debug and bench checking.

## Interface
Parameters:
- `WIDTH`, 8, data word width.
- `CNT_W`, 16, width of the transfer counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `a_data` in WIDTH: source A word.
- `a_valid` in 1: source A offers `a_data`.
- `a_ready` out 1: source A holding register is empty.
- `b_data` in WIDTH: source B word.
- `b_valid` in 1: source B offers `b_data`.
- `b_ready` out 1: source B holding register is empty.
- `out_data` out WIDTH: registered output word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `sel_a` out 1: origin of the word in `out_data`; 1 = A, 0 = B.
- `xfer_cnt` out CNT_W: count of completed output handshakes.

## Operation
- Per-source holding register `hold_x` with flag `full_x`.
  - `x_ready = ~full_x`; this is a registered value with no combinational path from `out_ready`.
  - On `x_valid & x_ready`, capture `x_data` and set `full_x`.
- Output slot is free when `~out_valid | out_ready`.
- Arbitration happens only when the output slot is free:
  - Only `full_a`: grant A.
  - Only `full_b`: grant B.
  - Both full: grant the source not granted last, using pointer `last_a` (1 = A granted last).
  - Neither full: no grant.
- On a grant to X:
  - `out_data <= hold_x` through the 2:1 mux, with select = grant.
  - `out_valid <= 1`, `sel_a <= (X==A)`, `full_x <= 0`, `last_a <= (X==A)`.
- Slot free with no grant: `out_valid <= 0`. `out_data` and `sel_a` keep their previous values.
- `out_valid & ~out_ready`: all output registers hold their values. Data must stay stable until accepted.
- `xfer_cnt` increments on every `out_valid & out_ready` and wraps modulo 2^CNT_W.
- The same holding register is never written and drained in the same cycle. A drained source shows `x_ready = 1` starting in the cycle after the grant.
- Reset values:
  - `full_a = full_b = 0`, so `a_ready = b_ready = 1` in the first cycle after reset.
  - `out_valid = 0`, `out_data = 0`, `sel_a = 0`, `xfer_cnt = 0`.
  - `last_a = 0`, so A wins the first tie.
- Reset during operation discards both held words and any pending output. No handshake completes in a cycle where `rst` is high.

## Timing
- Latency: a word accepted at edge k appears with `out_valid = 1` after edge k+1, provided the slot is free at k+1.
- Throughput:
  - One source alone: one word every 2 cycles, because its register cannot refill in the cycle it drains.
  - Both sources saturated with `out_ready = 1`: one word per cycle, in strict A/B alternation.
- Simultaneous input handshake on A and B in the same cycle: both are captured.
- Backpressure: with `out_ready = 0` for N cycles, at most 2 words are stalled inside the block (held) plus 1 in the output register.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic {GRANT_B = 1'b0, GRANT_A = 1'b1} grant_e`, used for the grant and `last_a` encoding.
  - Default constants `ARB_WIDTH = 8` and `ARB_CNT_W = 16`.
- Sub-module: instantiate the existing `mux_m` with `#(WIDTH)` for hold-to-output selection.
  - `data_a = hold_a`, `data_b = hold_b`, `sel_a` = current grant.
- Arbitration and flag logic go in one `always_ff`, with next-grant logic in an `always_comb`.

## Test plan
- Reset: hold `rst` 2 cycles with `a_valid = b_valid = 1` → `out_valid = 0`, `xfer_cnt = 0`, `a_ready = b_ready = 1` after release, and nothing captured during reset.
- Single source: A sends 0x11, 0x22 with `out_ready = 1` → `out_data` = 0x11 then 0x22, `sel_a = 1`, words 2 cycles apart, `xfer_cnt = 2`.
- Tie: A = 0xAA and B = 0xBB captured at the same edge → output order 0xAA (`sel_a = 1`) then 0xBB (`sel_a = 0`). A second tie → A first again.
- Saturation: both sources always valid with incrementing data, 20 cycles, `out_ready = 1` → output strictly alternates A, B, A, B at one word per cycle after a 2-cycle fill.
- Backpressure: `out_valid = 1` with 0x5C, `out_ready = 0` for 5 cycles → `out_data` holds 0x5C, both `x_ready` go to 0 once their registers fill, and `xfer_cnt` is unchanged. Releasing `out_ready` → 3 words drain in consecutive cycles.
- Wrap and mid-reset: `CNT_W = 4` with 17 transfers → `xfer_cnt = 1`. Assert `rst` while both registers are full → `xfer_cnt = 0`, `out_valid = 0` next cycle, and held words are never emitted.
